mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port, fixed-latency memory between IF (instruction fetch) and LS (MEM-stage load/store).
// - Sits between pipeline_core's fetch/MEM stages and the unified instruction/data RAM.
// - One outstanding transaction at a time; LS has priority, and a starvation guard protects IF.
// - Fetch flush (branch/jump redirect) support.
// PARAMETERS
// - ADDR_W      32  address width
// - DATA_W      32  data width
// - MEM_LAT     2   cycles from o_mem_req to valid i_mem_rdata (>=1)
// - STARVE_MAX  4   consecutive LS wins over a waiting IF before IF is forced ahead (>=1)
// PORTS
// - i_clk        in   1       clock, rising edge
// - i_reset      in   1       reset, asynchronous, active-low
// - i_if_req     in   1       fetch request; held until o_if_gnt
// - i_if_addr    in   ADDR_W  fetch address
// - i_if_flush   in   1       kill pending/new fetch (redirect)
// - o_if_gnt     out  1       fetch accepted this cycle
// - o_if_rvalid  out  1       fetch data valid (1-cycle pulse)
// - o_if_rdata   out  DATA_W  fetch data
// - i_ls_req     in   1       load/store request; held until o_ls_gnt
// - i_ls_we      in   1       1 = store
// - i_ls_addr    in   ADDR_W  load/store address
// - i_ls_wdata   in   DATA_W  store data
// - i_ls_be      in   4       store byte enables
// - o_ls_gnt     out  1       load/store accepted this cycle
// - o_ls_rvalid  out  1       load data / store ack (1-cycle pulse)
// - o_ls_rdata   out  DATA_W  load data; 0 on store ack
// - o_mem_req    out  1       memory access strobe
// - o_mem_we     out  1       memory write enable
// - o_mem_addr   out  ADDR_W  memory address, passed unmodified
// - o_mem_wdata  out  DATA_W  memory write data
// - o_mem_be     out  4       memory byte enables
// - i_mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after o_mem_req
// - o_busy       out  1       transaction in flight (state != IDLE)
// BEHAVIOUR
// - Reset (async, i_reset=0):
//   - state=IDLE; lat_cnt=0; starve_cnt=0; owner=none; kill=0.
//   - All outputs 0. An in-flight response is discarded.
// - FSM IDLE/WAIT.
// - Grant window: state==IDLE, or state==WAIT && lat_cnt==0 (response cycle). Gives back-to-back throughput.
// - In the grant window:
//   - If LS req and (starve_cnt<STARVE_MAX or no eligible IF) -> LS.
//   - Otherwise, if IF req and !i_if_flush -> IF.
//   - Eligible IF = i_if_req && !i_if_flush.
// - Grant cycle (all combinational, same cycle):
//   - o_*_gnt=1 and o_mem_req=1.
//   - o_mem_we/addr/wdata/be taken from the winner. IF grant forces we=0, be=4'hF, wdata=0.
//   - Next cycle: state=WAIT, lat_cnt=MEM_LAT-1, owner=winner, kill=0.
// - No grant in the window: memory outputs 0; state -> IDLE.
// - WAIT, lat_cnt>0: lat_cnt decrements each cycle.
// - Response cycle (WAIT, lat_cnt==0):
//   - Owner's o_*_rvalid=1. o_*_rdata = i_mem_rdata (load/fetch), 0 (store).
// - IF flush:
//   - i_if_flush in any cycle while owner==IF in WAIT sets kill. A killed response gives no o_if_rvalid and rdata 0.
//   - The memory side still completes; lat_cnt still runs.
//   - i_if_flush also blocks an IF grant that same cycle.
// - starve_cnt, updated on each grant-window cycle:
//   - +1 (saturate at STARVE_MAX) when LS wins while eligible IF is waiting.
//   - Cleared when IF wins or i_if_req==0.
// - Simultaneous LS and IF requests with starve_cnt==STARVE_MAX: IF wins; LS holds its request and wins next window.
// - Response and new grant in the same cycle are legal and independent.
// - o_*_rdata: 0 whenever o_*_rvalid==0.
// TESTING
// - MEM_LAT=2, IF req addr 0x10, mem returns 0xDEADBEEF:
//   - gnt at t0, o_mem_addr=0x10, we=0; o_if_rvalid at t2 with 0xDEADBEEF; o_busy t1..t2.
// - IF and LS load both request at t0:
//   - o_ls_gnt at t0, o_if_gnt at t0+MEM_LAT (response cycle); each rvalid goes to the correct owner.
// - LS req held high continuously, IF waiting, STARVE_MAX=4:
//   - LS wins 4 windows, IF wins the 5th; starve_cnt returns to 0.
// - IF granted, i_if_flush pulsed at t1 (MEM_LAT=2):
//   - No o_if_rvalid at t2; o_mem_req was issued once; a next IF req grants normally.
// - Store with be=4'b0011, addr 0x200, wdata 0x1234:
//   - mem outputs match at gnt; o_ls_rvalid pulse with rdata=0 after MEM_LAT.
// - i_reset low mid-WAIT:
//   - All outputs 0 immediately (async); no rvalid after release; the first request after release is granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch (IF)
// and load/store (LS). LS normally wins, but IF is forced through after STARVE_MAX consecutive LS wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  localparam int SC_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // fetch port
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  // load/store port
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  input  logic [3:0]        i_ls_be,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  // memory port
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic [DATA_W-1:0] i_mem_rdata,
  // status / debug
  output logic              o_busy,
  output logic              o_dbg_state,
  output logic [SC_W-1:0]   o_dbg_starve_cnt
);

  // Handshake: a requester holds req (and its payload) until it sees gnt in the
  // same cycle; exactly MEM_LAT cycles later the owner gets a one-cycle rvalid.

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              kill_q, kill_d;
  logic              ls_we_q, ls_we_d;

  logic              window;
  logic              resp;
  logic              if_elig;
  logic              ls_win;
  logic              if_win;
  logic              grant;

  // Gating with i_reset keeps every output at 0 for the whole reset pulse,
  // even though the request inputs feed the grant path combinationally.
  assign window  = i_reset && ((state_q == S_IDLE) || (lat_q == '0));
  assign resp    = i_reset && (state_q == S_WAIT) && (lat_q == '0);
  assign if_elig = i_if_req && !i_if_flush;
  assign ls_win  = window && i_ls_req && ((starve_q < SC_W'(STARVE_MAX)) || !if_elig);
  assign if_win  = window && !ls_win && if_elig;
  assign grant   = ls_win || if_win;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      lat_q    <= '0;
      starve_q <= '0;
      kill_q   <= 1'b0;
      ls_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      kill_q   <= kill_d;
      ls_we_q  <= ls_we_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    kill_d   = kill_q;
    ls_we_d  = ls_we_q;

    if (grant) begin
      state_d = S_WAIT;
      lat_d   = LAT_W'(MEM_LAT - 1);
      owner_d = ls_win ? OWN_LS : OWN_IF;
      kill_d  = 1'b0;
      ls_we_d = ls_win && i_ls_we;
    end else if (window) begin
      state_d = S_IDLE;
      owner_d = OWN_NONE;
      kill_d  = 1'b0;
      ls_we_d = 1'b0;
    end else if (state_q == S_WAIT) begin
      lat_d = lat_q - LAT_W'(1);
      if ((owner_q == OWN_IF) && i_if_flush) begin
        kill_d = 1'b1;
      end
    end

    // Starvation count only moves on arbitration cycles.
    if (window) begin
      if (ls_win && if_elig) begin
        if (starve_q != SC_W'(STARVE_MAX)) begin
          starve_d = starve_q + SC_W'(1);
        end
      end else if (if_win || !i_if_req) begin
        starve_d = '0;
      end
    end
  end

  // Output logic
  always_comb begin
    o_if_gnt    = if_win;
    o_ls_gnt    = ls_win;
    o_mem_req   = grant;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = 4'h0;
    o_if_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_ls_rvalid = 1'b0;
    o_ls_rdata  = '0;

    if (ls_win) begin
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_be    = i_ls_be;
    end else if (if_win) begin
      o_mem_addr  = i_if_addr;
      o_mem_be    = 4'hF;
    end

    // A flush arriving in the response cycle itself also drops the stale fetch.
    if (resp && (owner_q == OWN_IF) && !kill_q && !i_if_flush) begin
      o_if_rvalid = 1'b1;
      o_if_rdata  = i_mem_rdata;
    end
    if (resp && (owner_q == OWN_LS)) begin
      o_ls_rvalid = 1'b1;
      o_ls_rdata  = ls_we_q ? '0 : i_mem_rdata;
    end
  end

  assign o_busy           = i_reset && (state_q == S_WAIT);
  assign o_dbg_state      = state_q;
  assign o_dbg_starve_cnt = starve_q;

`ifndef SYNTHESIS
  a_one_grant: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(o_if_gnt && o_ls_gnt));
  a_one_rvalid: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(o_if_rvalid && o_ls_rvalid));
  a_grant_in_window: assert property (@(posedge i_clk) disable iff (!i_reset)
    o_mem_req |-> ((state_q == S_IDLE) || (lat_q == '0)));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4): inputs change just
// after the falling edge, outputs are sampled 1 ns later, well clear of the rising edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_if_req = 1'b0;
  logic [ADDR_W-1:0] i_if_addr = '0;
  logic              i_if_flush = 1'b0;
  logic              o_if_gnt, o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;
  logic              i_ls_req = 1'b0;
  logic              i_ls_we = 1'b0;
  logic [ADDR_W-1:0] i_ls_addr = '0;
  logic [DATA_W-1:0] i_ls_wdata = '0;
  logic [3:0]        i_ls_be = 4'h0;
  logic              o_ls_gnt, o_ls_rvalid;
  logic [DATA_W-1:0] o_ls_rdata;
  logic              o_mem_req, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [3:0]        o_mem_be;
  logic [DATA_W-1:0] i_mem_rdata = '0;
  logic              o_busy, o_dbg_state;
  logic [2:0]        o_dbg_starve_cnt;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_be(i_ls_be),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state), .o_dbg_starve_cnt(o_dbg_starve_cnt)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    #2;
    i_reset  = 1'b0;
    i_if_req = 1'b1;
    i_ls_req = 1'b1;
    #1;
    checks++;
    if ({o_if_gnt, o_ls_gnt, o_mem_req, o_mem_we, o_busy, o_if_rvalid, o_ls_rvalid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {o_if_gnt, o_ls_gnt, o_mem_req, o_mem_we, o_busy, o_if_rvalid, o_ls_rvalid});
    end
    checks++;
    if ({o_mem_addr, o_mem_be, o_dbg_starve_cnt, o_dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr %h be %h starve %0d st %b exp 0", o_mem_addr, o_mem_be, o_dbg_starve_cnt, o_dbg_state);
    end
    cyc();
    i_if_req = 1'b0;
    i_ls_req = 1'b0;
    cyc();
    i_reset = 1'b1;
  endtask

  task automatic test_if_fetch();
    cyc();
    i_if_req = 1'b1; i_if_addr = 32'h10;
    #1;
    checks++;
    if ({o_if_gnt, o_mem_req, o_mem_we, o_busy} !== 4'b1100) begin
      errors++;
      $display("FAIL if_gnt got %b exp 1100", {o_if_gnt, o_mem_req, o_mem_we, o_busy});
    end
    checks++;
    if (o_mem_addr !== 32'h10 || o_mem_be !== 4'hF || o_mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL if_mem_out got addr %h be %h wd %h exp 10 f 0", o_mem_addr, o_mem_be, o_mem_wdata);
    end
    cyc();
    i_if_req = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_mem_req, o_if_rvalid} !== 3'b100) begin
      errors++;
      $display("FAIL if_t1 got %b exp 100", {o_busy, o_mem_req, o_if_rvalid});
    end
    cyc();
    i_mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (o_if_rvalid !== 1'b1 || o_if_rdata !== 32'hDEADBEEF || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL if_resp got v %b d %h busy %b exp 1 deadbeef 1", o_if_rvalid, o_if_rdata, o_busy);
    end
    cyc();
    i_mem_rdata = 32'h0;
    #1;
    checks++;
    if ({o_busy, o_if_rvalid} !== 2'b00 || o_if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL if_idle got busy %b v %b d %h exp 0 0 0", o_busy, o_if_rvalid, o_if_rdata);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    i_if_req = 1'b1; i_if_addr = 32'h10;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h300;
    #1;
    checks++;
    if ({o_ls_gnt, o_if_gnt} !== 2'b10 || o_mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL b2b_ls_first got gnt %b addr %h exp 10 300", {o_ls_gnt, o_if_gnt}, o_mem_addr);
    end
    cyc();
    i_ls_req = 1'b0;
    #1;
    checks++;
    if ({o_if_gnt, o_mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_no_gnt got %b exp 00", {o_if_gnt, o_mem_req});
    end
    cyc();
    i_mem_rdata = 32'h0000A5A5;
    #1;
    checks++;
    if (o_ls_rvalid !== 1'b1 || o_ls_rdata !== 32'h0000A5A5 || o_if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ls_resp got v %b d %h ifv %b exp 1 a5a5 0", o_ls_rvalid, o_ls_rdata, o_if_rvalid);
    end
    checks++;
    if ({o_if_gnt, o_ls_gnt} !== 2'b10 || o_mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL b2b_if_gnt got gnt %b addr %h exp 10 10", {o_if_gnt, o_ls_gnt}, o_mem_addr);
    end
    cyc();
    i_if_req = 1'b0;
    i_mem_rdata = 32'h0;
    #1;
    checks++;
    if (o_dbg_starve_cnt !== 3'd0) begin
      errors++;
      $display("FAIL b2b_starve got %0d exp 0", o_dbg_starve_cnt);
    end
    cyc();
    i_mem_rdata = 32'h11112222;
    #1;
    checks++;
    if (o_if_rvalid !== 1'b1 || o_if_rdata !== 32'h11112222 || o_ls_rvalid !== 1'b0 || o_ls_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_if_resp got v %b d %h lsv %b lsd %h exp 1 11112222 0 0", o_if_rvalid, o_if_rdata, o_ls_rvalid, o_ls_rdata);
    end
    cyc();
    i_mem_rdata = 32'h0;
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 5; k++) begin
      cyc();
      i_if_req = 1'b1; i_if_addr = 32'h20;
      i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h100 + k;
      i_mem_rdata = 32'h5000 + k;
      #1;
      checks++;
      if ({o_ls_gnt, o_if_gnt} !== ((k < 4) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL starve_win k=%0d got %b exp %b", k, {o_ls_gnt, o_if_gnt}, (k < 4) ? 2'b10 : 2'b01);
      end
      if (k > 0) begin
        checks++;
        if (o_ls_rvalid !== 1'b1 || o_ls_rdata !== 32'h5000 + k) begin
          errors++;
          $display("FAIL starve_resp k=%0d got v %b d %h exp 1 %h", k, o_ls_rvalid, o_ls_rdata, 32'h5000 + k);
        end
      end
      cyc();
      if (k == 4) begin
        i_if_req = 1'b0;
        i_ls_req = 1'b0;
      end
      i_mem_rdata = 32'h0;
      #1;
      checks++;
      if (o_mem_req !== 1'b0 || o_dbg_starve_cnt !== ((k < 4) ? 3'(k + 1) : 3'd0)) begin
        errors++;
        $display("FAIL starve_cnt k=%0d got req %b cnt %0d exp 0 %0d", k, o_mem_req, o_dbg_starve_cnt, (k < 4) ? k + 1 : 0);
      end
    end
    cyc();
    cyc();
  endtask

  task automatic test_flush();
    cyc();
    i_if_req = 1'b1; i_if_flush = 1'b1; i_if_addr = 32'h3C;
    #1;
    checks++;
    if ({o_if_gnt, o_mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL flush_block got %b exp 00", {o_if_gnt, o_mem_req});
    end
    cyc();
    i_if_flush = 1'b0; i_if_addr = 32'h40;
    #1;
    checks++;
    if ({o_if_gnt, o_mem_req} !== 2'b11 || o_mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL flush_gnt got %b addr %h exp 11 40", {o_if_gnt, o_mem_req}, o_mem_addr);
    end
    cyc();
    i_if_req = 1'b0; i_if_flush = 1'b1;
    #1;
    checks++;
    if (o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_t1_req got %b exp 0", o_mem_req);
    end
    cyc();
    i_if_flush = 1'b0; i_mem_rdata = 32'h0000BBBB;
    #1;
    checks++;
    if ({o_if_rvalid, o_mem_req, o_busy} !== 3'b001 || o_if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL flush_killed got v/req/busy %b d %h exp 001 0", {o_if_rvalid, o_mem_req, o_busy}, o_if_rdata);
    end
    cyc();
    i_mem_rdata = 32'h0;
    i_if_req = 1'b1; i_if_addr = 32'h44;
    #1;
    checks++;
    if (o_if_gnt !== 1'b1 || o_mem_addr !== 32'h44) begin
      errors++;
      $display("FAIL flush_regrant got gnt %b addr %h exp 1 44", o_if_gnt, o_mem_addr);
    end
    cyc();
    i_if_req = 1'b0;
    cyc();
    i_mem_rdata = 32'h0000CCCC;
    #1;
    checks++;
    if (o_if_rvalid !== 1'b1 || o_if_rdata !== 32'h0000CCCC) begin
      errors++;
      $display("FAIL flush_next_resp got v %b d %h exp 1 cccc", o_if_rvalid, o_if_rdata);
    end
    cyc();
    i_mem_rdata = 32'h0;
  endtask

  task automatic test_store();
    cyc();
    i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_addr = 32'h200;
    i_ls_wdata = 32'h1234; i_ls_be = 4'b0011;
    #1;
    checks++;
    if ({o_ls_gnt, o_mem_req, o_mem_we} !== 3'b111 || o_mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL store_gnt got %b addr %h exp 111 200", {o_ls_gnt, o_mem_req, o_mem_we}, o_mem_addr);
    end
    checks++;
    if (o_mem_wdata !== 32'h1234 || o_mem_be !== 4'b0011) begin
      errors++;
      $display("FAIL store_data got wd %h be %b exp 1234 0011", o_mem_wdata, o_mem_be);
    end
    cyc();
    i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_wdata = 32'h0; i_ls_be = 4'h0;
    cyc();
    i_mem_rdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (o_ls_rvalid !== 1'b1 || o_ls_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_ack got v %b d %h exp 1 0", o_ls_rvalid, o_ls_rdata);
    end
    cyc();
    i_mem_rdata = 32'h0;
  endtask

  task automatic test_reset_mid_wait();
    cyc();
    i_if_req = 1'b1; i_if_addr = 32'h80;
    #1;
    checks++;
    if (o_if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_gnt got %b exp 1", o_if_gnt);
    end
    cyc();
    i_if_req = 1'b0;
    #2;
    i_reset = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_dbg_state, o_mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL rst_async got %b exp 000", {o_busy, o_dbg_state, o_mem_req});
    end
    i_if_req = 1'b1;
    #1;
    checks++;
    if ({o_if_gnt, o_mem_req, o_mem_be} !== 6'b0) begin
      errors++;
      $display("FAIL rst_no_gnt got %b exp 0", {o_if_gnt, o_mem_req, o_mem_be});
    end
    cyc();
    i_mem_rdata = 32'h77;
    #1;
    checks++;
    if ({o_if_rvalid, o_ls_rvalid} !== 2'b00 || o_if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_rvalid got %b d %h exp 00 0", {o_if_rvalid, o_ls_rvalid}, o_if_rdata);
    end
    i_if_req = 1'b0;
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_if_rvalid, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_release got %b exp 00", {o_if_rvalid, o_busy});
    end
    cyc();
    i_mem_rdata = 32'h0;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h500;
    #1;
    checks++;
    if ({o_ls_gnt, o_busy, o_dbg_state} !== 3'b100 || o_mem_addr !== 32'h500) begin
      errors++;
      $display("FAIL rst_first_gnt got %b addr %h exp 100 500", {o_ls_gnt, o_busy, o_dbg_state}, o_mem_addr);
    end
    cyc();
    i_ls_req = 1'b0;
    cyc();
    i_mem_rdata = 32'h99;
    #1;
    checks++;
    if (o_ls_rvalid !== 1'b1 || o_ls_rdata !== 32'h99) begin
      errors++;
      $display("FAIL rst_first_resp got v %b d %h exp 1 99", o_ls_rvalid, o_ls_rdata);
    end
    cyc();
    i_mem_rdata = 32'h0;
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_back_to_back();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
